mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_arb_pkg;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 15;
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requester after last_gnt (wrapping) wins.
// Latency: combinational.
// Backpressure: none; grant is all-zero when nothing requests.
module rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt
);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = IDX_W'((int'(last_gnt) + off) % NUM_REQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a single-command memory controller; optional MEM_ARB_TIMEOUT_EN.
// Latency: request to done_req is 4 cycles (IDLE, ISSUE, WAIT, DONE) with ready_sys in the first WAIT cycle.
// Backpressure: requesters hold cmd_valid_req until done_req; WAIT stalls until ready_sys (or timeout).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              cmd_valid_req,
    input  logic [NUM_REQ-1:0]              we_req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_req,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_req,
    output logic [NUM_REQ-1:0]              gnt_req,
    output logic [NUM_REQ-1:0]              done_req,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic [NUM_REQ-1:0]              err_req,
`endif
    output logic [DATA_W-1:0]               rdata_req,
    output logic                            we_sys,
    output logic                            cmd_valid_sys,
    output logic [ADDR_W-1:0]               addr_sys,
    output logic [DATA_W-1:0]               wdata_sys,
    output logic                            data_oe_sys,
    input  logic [DATA_W-1:0]               rdata_sys,
    input  logic                            ready_sys
);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    win_idx;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
`endif

    rr_arbiter u_rr (
        .req      (cmd_valid_req),
        .last_gnt (last_q),
        .gnt      (arb_gnt)
    );

    assign win_idx = onehot_to_idx(arb_gnt);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (|cmd_valid_req) begin
                    gnt_d   = arb_gnt;
                    last_d  = win_idx;
                    we_d    = we_req[win_idx];
                    addr_d  = addr_req[win_idx];
                    wdata_d = wdata_req[win_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
                timeout_d  = 1'b0;
`endif
            end
            WAIT: begin
                if (ready_sys) begin
                    if (!we_q) rdata_d = rdata_sys;
                    state_d = DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == 4'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to the final requester so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt_req       = gnt_q;
    assign done_req      = (state_q == DONE) ? gnt_q : '0;
    assign rdata_req     = rdata_q;
    assign we_sys        = we_q;
    assign addr_sys      = addr_q;
    assign wdata_sys     = wdata_q;
    assign cmd_valid_sys = (state_q == ISSUE);
    assign data_oe_sys   = we_q && ((state_q == ISSUE) || (state_q == WAIT));
`ifdef MEM_ARB_TIMEOUT_EN
    assign err_req       = (state_q == DONE && timeout_q) ? gnt_q : '0;
`endif

endmodule
